// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Opcodes, FSM state encoding and sizing shared by the SPI
//               master controller and the slave-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int CNT_W   = 4;
  localparam int BYTE_W  = 8;

  typedef logic [1:0] op_t;

  localparam op_t WR_ADDR = 2'b00;
  localparam op_t WR_DATA = 2'b01;
  localparam op_t RD_ADDR = 2'b10;
  localparam op_t RD_DATA = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_RECV  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Slave select is asserted for every state that belongs to a frame body.
  function automatic logic ss_active(input state_t s);
    return (s == ST_START) || (s == ST_SHIFT) || (s == ST_WAIT) || (s == ST_RECV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_reg
// Description : Parallel-load shift register, serial-out MSB first, with
//               serial-in at the LSB for receiving a byte.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_reg #(
  parameter int W    = 10,
  parameter int RX_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [W-1:0]    load_data,
  input  logic            shift_en,
  input  logic            serial_in,
  output logic            serial_out,
  output logic [RX_W-1:0] rx_next
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {data_q[W-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign serial_out = data_q[W-1];
  // Received byte as it will look once the bit currently on serial_in lands.
  assign rx_next    = {data_q[RX_W-2:0], serial_in};

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : SPI master issuing 10-bit {op,payload} frames, with an
//               optional latency wait and 8-bit receive for read-data frames.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int GAP        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [BYTE_W-1:0] cmd_payload,
  output logic              done,
  output logic              rsp_valid,
  output logic [BYTE_W-1:0] rsp_data,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  op_t               op_q, op_d;
  logic [BYTE_W-1:0] rsp_data_q, rsp_data_d;
  logic              rdy_en_q;

  logic              accept;
  logic              sr_shift;
  logic              sr_msb;
  logic [BYTE_W-1:0] rx_next;

  assign accept = cmd_valid && cmd_ready;

  spi_shift_reg #(
    .W    (FRAME_W),
    .RX_W (BYTE_W)
  ) u_shift_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_data  ({cmd_op, cmd_payload}),
    .shift_en   (sr_shift),
    .serial_in  (MISO),
    .serial_out (sr_msb),
    .rx_next    (rx_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_q == BITS_LAST) begin
          case (op_q)
            RD_DATA:                   state_d = (RD_LATENCY == 0) ? ST_RECV : ST_WAIT;
            WR_ADDR, WR_DATA, RD_ADDR: state_d = ST_DONE;
          endcase
        end
      end
      ST_WAIT:  if (cnt_q == LAT_LAST) state_d = ST_RECV;
      ST_RECV:  if (cnt_q == RX_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && (gap_q == '0) && rdy_en_q;
    SS_n      = !ss_active(state_q);
    MOSI      = ((state_q == ST_START) || (state_q == ST_SHIFT)) && sr_msb;
    done      = (state_q == ST_DONE);
    rsp_valid = (state_q == ST_DONE) && (op_q == RD_DATA);
    rsp_data  = rsp_data_q;
  end

  // Counters restart on every state change so each phase counts from zero.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) &&
        ((state_q == ST_SHIFT) || (state_q == ST_WAIT) || (state_q == ST_RECV))) begin
      cnt_d = cnt_q + 1'b1;
    end

    gap_d = gap_q;
    if (state_q == ST_DONE) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end

    op_d       = accept ? cmd_op : op_q;
    sr_shift   = (state_q == ST_SHIFT) || (state_q == ST_RECV);
    rsp_data_d = rsp_data_q;
    if ((state_q == ST_RECV) && (cnt_q == RX_LAST)) begin
      rsp_data_d = rx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      gap_q      <= '0;
      op_q       <= WR_ADDR;
      rsp_data_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rdy_en_q   <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Directed bench for spi_master_ctrl (RD_LATENCY=2 and =0 builds)
//               against a behavioural SPI slave with a byte RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid   [2];
  logic       cmd_ready   [2];
  logic [1:0] cmd_op      [2];
  logic [7:0] cmd_payload [2];
  logic       done        [2];
  logic       rsp_valid   [2];
  logic [7:0] rsp_data    [2];
  logic       ss_n        [2];
  logic       mosi        [2];
  logic       miso        [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_LATENCY(LAT_A), .GAP(1)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_payload(cmd_payload[0]), .done(done[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .SS_n(ss_n[0]),
    .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_master_ctrl #(.RD_LATENCY(LAT_B), .GAP(1)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_payload(cmd_payload[1]), .done(done[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .SS_n(ss_n[1]),
    .MOSI(mosi[1]), .MISO(miso[1])
  );

  // Slave model and bus monitor state, one entry per DUT.
  int          n         [2] = '{0, 0};
  int          high_run  [2] = '{0, 0};
  int          last_gap  [2] = '{0, 0};
  int          last_len  [2] = '{0, 0};
  int          frames    [2] = '{0, 0};
  int          done_cnt  [2] = '{0, 0};
  int          rsp_cnt   [2] = '{0, 0};
  int          ready_bad [2] = '{0, 0};
  int          mosi_bad  [2] = '{0, 0};
  logic [10:0] bits      [2] = '{11'd0, 11'd0};
  logic [10:0] last_bits [2] = '{11'd0, 11'd0};
  logic [7:0]  last_rsp  [2] = '{8'd0, 8'd0};
  logic [7:0]  addr      [2] = '{8'd0, 8'd0};
  logic [7:0]  rdbyte    [2] = '{8'd0, 8'd0};
  logic [7:0]  mem       [2][256];

  always @(negedge clk) begin
    int r;
    for (int k = 0; k < 2; k++) begin
      if (done[k] === 1'b1) done_cnt[k]++;
      if (rsp_valid[k] === 1'b1) begin
        rsp_cnt[k]++;
        last_rsp[k] = rsp_data[k];
      end
      if (rst) begin
        n[k]        = 0;
        high_run[k] = 0;
        miso[k]     = 1'b0;
      end else if (ss_n[k] === 1'b0) begin
        if (n[k] == 0) last_gap[k] = high_run[k];
        if (cmd_ready[k] === 1'b1) ready_bad[k]++;
        if (n[k] < 11) bits[k] = {bits[k][9:0], mosi[k]};
        if (n[k] == 10) begin
          case (bits[k][9:8])
            2'b00:   addr[k] = bits[k][7:0];
            2'b01:   mem[k][addr[k]] = bits[k][7:0];
            2'b10:   addr[k] = bits[k][7:0];
            default: rdbyte[k] = mem[k][addr[k]];
          endcase
        end
        r = n[k] - 11 - ((k == 0) ? LAT_A : LAT_B);
        miso[k] = (n[k] >= 11 && bits[k][9:8] == 2'b11 && r >= 0 && r < 8) ? rdbyte[k][7-r] : 1'b0;
        n[k]++;
      end else begin
        if (mosi[k] !== 1'b0) mosi_bad[k]++;
        if (n[k] != 0) begin
          last_len[k]  = n[k];
          last_bits[k] = bits[k];
          frames[k]++;
          n[k]        = 0;
          high_run[k] = 0;
        end
        high_run[k]++;
        miso[k] = 1'b0;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a command and returns just after the accepting edge; cmd_valid stays high.
  task automatic issue(input int k, input logic [1:0] op, input logic [7:0] pl);
    bit got;
    got = 1'b0;
    cmd_op[k]      = op;
    cmd_payload[k] = pl;
    cmd_valid[k]   = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready[k] === 1'b1) got = 1'b1;
    end
    check("accept_timeout", {31'd0, got}, 32'd1);
    if (got) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done[k] === 1'b1) got = 1'b1;
    end
    check("done_timeout", {31'd0, got}, 32'd1);
    if (got) check("ss_n_high_in_done", {31'd0, ss_n[k]}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int k, input logic [1:0] op, input logic [7:0] pl);
    issue(k, op, pl);
    cmd_valid[k] = 1'b0;
    wait_done(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k]   = 1'b0;
      cmd_op[k]      = 2'b00;
      cmd_payload[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_ss_n",      {31'd0, ss_n[0]},      32'd1);
    check("rst_mosi",      {31'd0, mosi[0]},      32'd0);
    check("rst_done",      {31'd0, done[0]},      32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst_rsp_data",  {24'd0, rsp_data[0]},  32'h00);
    check("rst_cmd_ready", {31'd0, cmd_ready[0]}, 32'd0);
    check("rst_ss_n_b",    {31'd0, ss_n[1]},      32'd1);
    rst = 1'b0;
    check("ready_after_deassert", {31'd0, cmd_ready[0]}, 32'd0);
    @(posedge clk);
    #1;
    check("ready_one_cycle_later", {31'd0, cmd_ready[0]}, 32'd1);

    // Write address 0x3C: rw bit 0, op 00, payload 0011_1100.
    xfer(0, 2'b00, 8'h3C);
    check("wa_len",       last_len[0],  32'd11);
    check("wa_bits",      {21'd0, last_bits[0]}, {21'd0, 11'b000_0011_1100});
    check("wa_done_cnt",  done_cnt[0],  32'd1);
    check("wa_no_rsp",    rsp_cnt[0],   32'd0);

    xfer(0, 2'b01, 8'hA5);
    // Read data from address 0x3C, RD_LATENCY=2.
    xfer(0, 2'b11, 8'h00);
    check("rd_len",       last_len[0],  32'd21);
    check("rd_bits",      {21'd0, last_bits[0]}, {21'd0, 1'b1, 2'b11, 8'h00});
    check("rd_rsp_cnt",   rsp_cnt[0],   32'd1);
    check("rd_rsp_data",  {24'd0, last_rsp[0]}, 32'hA5);

    // rsp_data holds across a non-read-data frame.
    xfer(0, 2'b01, 8'h77);
    check("hold_rsp_data", {24'd0, rsp_data[0]}, 32'hA5);
    check("hold_rsp_cnt",  rsp_cnt[0],  32'd1);

    // Back-to-back with cmd_valid held high: DONE + GAP cycle + accepting cycle.
    d0 = done_cnt[0];
    issue(0, 2'b00, 8'h10);
    issue(0, 2'b01, 8'h5A);
    cmd_valid[0] = 1'b0;
    wait_done(0);
    check("b2b_done_cnt", done_cnt[0] - d0, 32'd2);
    check("b2b_gap",      last_gap[0],  32'd3);
    check("b2b_bits",     {21'd0, last_bits[0]}, {21'd0, 1'b0, 2'b01, 8'h5A});
    check("b2b_ready_in_frame", ready_bad[0], 32'd0);

    // End-to-end readback of the byte just written to 0x10.
    xfer(0, 2'b10, 8'h10);
    xfer(0, 2'b11, 8'h00);
    check("e2e_rsp_data", {24'd0, last_rsp[0]}, 32'h5A);
    check("e2e_rsp_out",  {24'd0, rsp_data[0]}, 32'h5A);

    // Reset after 5 SHIFT bits of an 0xFF write; next MOSI bit would be a 1.
    d0 = done_cnt[0];
    f0 = frames[0];
    issue(0, 2'b00, 8'hFF);
    cmd_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_shift_mosi", {31'd0, mosi[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ss_n",     {31'd0, ss_n[0]},      32'd1);
    check("abort_mosi",     {31'd0, mosi[0]},      32'd0);
    check("abort_ready",    {31'd0, cmd_ready[0]}, 32'd0);
    check("abort_rsp_data", {24'd0, rsp_data[0]},  32'h00);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done",  done_cnt[0] - d0, 32'd0);
    check("abort_no_frame", frames[0] - f0,   32'd0);
    xfer(0, 2'b10, 8'hA3);
    check("post_rst_len",  last_len[0], 32'd11);
    check("post_rst_bits", {21'd0, last_bits[0]}, {21'd0, 1'b1, 2'b10, 8'hA3});

    // RD_LATENCY=0 build: RECV follows SHIFT directly.
    xfer(1, 2'b00, 8'h3C);
    xfer(1, 2'b01, 8'hC3);
    xfer(1, 2'b11, 8'h00);
    check("lat0_len",      last_len[1], 32'd19);
    check("lat0_rsp_data", {24'd0, last_rsp[1]}, 32'hC3);
    check("lat0_rsp_cnt",  rsp_cnt[1],  32'd1);

    check("mosi_idle_a",  mosi_bad[0],  32'd0);
    check("mosi_idle_b",  mosi_bad[1],  32'd0);
    check("ready_bad_b",  ready_bad[1], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
